bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
Read-side master for the single-port BRAM (1-cycle registered read latency). It accepts a (start address, length) command, issues sequential reads on the BRAM port, and absorbs the read latency in a 2-entry buffer. Data leaves on a valid/ready stream with backpressure and a last flag. Traceback and readout logic in the WFA datapath use it to stream stored wavefront/pointer words.

Parameters:
ADDR_WIDTH, 8, BRAM address width; must match the attached BRAM.
DATA_WIDTH, 16, BRAM word width.
LEN_WIDTH, ADDR_WIDTH+1, command length width; allows a full-memory read of 2**ADDR_WIDTH words.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
start  in  1  command strobe; sampled only when busy=0
start_addr  in  ADDR_WIDTH  first word address
length  in  LEN_WIDTH  number of words to read
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
mem_addr  out  ADDR_WIDTH  BRAM address
mem_wen  out  1  BRAM write enable; constant 0
mem_dout  in  DATA_WIDTH  BRAM read data, valid the cycle after the address is presented
out_valid  out  1  stream data valid
out_data  out  DATA_WIDTH  stream data
out_last  out  1  marks the final word of the command
out_ready  in  1  downstream accept

Behaviour:
- One clock, clk. Reset is synchronous and active high (rst). Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_addr=0, buffer empty, in-flight flag=0, state IDLE.
- FSM states:
  - IDLE -> READ on start with length!=0.
  - IDLE -> IDLE on start with length==0; done pulses the next cycle and no beats are produced.
  - READ -> DRAIN after the final read is issued.
  - DRAIN -> IDLE on the handshake of the beat with out_last=1; done pulses the following cycle.
- busy=1 in READ and DRAIN. start is ignored while busy=1.
- Command capture on accepted start:
  - addr_q <= start_addr.
  - issue_cnt <= length.
  - beat_cnt <= length.
- Issue rule: in READ, issue = (occ + inflight - pop) < 2, where pop = out_valid & out_ready.
  - On issue: addr_q increments, issue_cnt decrements.
  - mem_addr = addr_q, driven combinationally.
  - The ready-to-issue combinational path is accepted.
- Latency:
  - A read issued in cycle t sets inflight for cycle t+1.
  - mem_dout is written into the buffer at the end of cycle t+1.
  - out_valid is visible in cycle t+2.
  - start at cycle 0 gives the first issue at cycle 1 and first out_valid at cycle 3.
- Throughput: one word per cycle when out_ready is held high.
- Buffer: 2-entry FIFO, head drives out_data.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - The buffer never overflows; the issue rule guarantees this. The bench asserts it.
- out_last = 1 on the beat where beat_cnt==1. beat_cnt decrements on each pop.
- Address wrap: addr_q increments modulo 2**ADDR_WIDTH, so start_addr+length past the top wraps to 0.
- Simultaneous push and pop in one cycle: occupancy is unchanged and ordering is preserved.
- out_ready may toggle arbitrarily. Stalls never drop or duplicate words.
- rst mid-command: returns to the reset state next cycle. In-flight data is discarded and done is not pulsed.

Decomposition:
- Package bram_rd_pkg:
  - state enum {IDLE, READ, DRAIN}.
  - Constant BUF_DEPTH=2.
- Sub-module rd_skid_fifo: 2-entry, DATA_WIDTH+1 wide, carrying data+last. Ports: push, din, pop, dout, occ.

Test Plan:
- BRAM preloaded mem[i]=i+16'h100. start_addr=5, length=4, out_ready=1 -> beats 0x105..0x108, first out_valid at cycle 3, one per cycle, out_last on 0x108, done pulse one cycle after.
- Same command with out_ready toggling 1,0,0,1,0,1... -> identical 4-word sequence, data stable during stalls, no duplicates.
- start_addr=254, length=4 (ADDR_WIDTH=8) -> data from addresses 254, 255, 0, 1.
- length=0 -> no out_valid, done pulse the cycle after start, busy stays 0.
- start asserted while busy -> ignored; only the original command's beats appear.
- rst asserted two cycles after first out_valid -> next cycle out_valid=0 and busy=0, no done. A fresh command (addr 0, length 2) afterwards returns 0x100, 0x101 correctly.

Source files
------------

// File: rtl/bram_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rd_pkg
//  Description : Shared types and constants for the BRAM stream reader.
//                - state_t   : reader control states
//                - BUF_DEPTH : depth of the read-latency buffer
//  Revision    : 1.0  initial release
// ============================================================================
package bram_rd_pkg;

  // Two entries are enough to cover one word in the buffer plus one word
  // still in flight from the BRAM, which is what sustains one word per cycle.
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bram_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_reader_if
//  Description : Command, BRAM-port and output-stream signals of the reader.
//                master : reader side (drives busy/done/mem_*/out_* outputs)
//                slave  : environment side (drives command, read data, ready)
//  Ports       : none (signal bundle only)
//  Revision    : 1.0  initial release
// ============================================================================
interface bram_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  // command
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  // BRAM port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_dout;
  // output stream
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    input  start, start_addr, length, mem_dout, out_ready,
    output busy, done, mem_addr, mem_wen, out_valid, out_data, out_last
  );

  modport slave (
    output start, start_addr, length, mem_dout, out_ready,
    input  busy, done, mem_addr, mem_wen, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/rd_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rd_skid_fifo
//  Description : Two-entry FIFO absorbing the BRAM read latency. The head
//                entry is presented on dout; simultaneous push and pop keep
//                occupancy constant and preserve order.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                push, din  - write one entry
//                pop        - remove the head entry
//                dout       - head entry
//                occ        - number of stored entries (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module rd_skid_fifo
  import bram_rd_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic      [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

  assign dout = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_reader
//  Description : Read-side master for a single-port BRAM with one cycle of
//                registered read latency. Accepts (start_addr, length),
//                issues sequential reads and streams the words out on a
//                valid/ready interface with a last flag.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active high
//                bus  - master modport: command (start/start_addr/length,
//                       busy/done), BRAM port (mem_addr/mem_wen/mem_dout),
//                       stream (out_valid/out_data/out_last/out_ready)
//  Revision    : 1.0  initial release
// ============================================================================
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bram_stream_reader_if.master  bus
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  done_q, done_d;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  pop;
  logic                  issue;
  logic [2:0]            occ_sum;
  logic [1:0]            occ;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  out_valid;

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & bus.out_ready;

  // Count a word as occupying the buffer from the cycle it is issued; the
  // word popped this cycle frees its slot immediately, so the buffer can
  // never be oversubscribed while still sustaining one word per cycle.
  assign occ_sum = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (state_q == READ) && (occ_sum < 3'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;

    if (pop) begin
      beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d      = bus.start_addr;
          issue_cnt_d = bus.length;
          beat_cnt_d  = bus.length;
          if (bus.length != '0) begin
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
          if (issue_cnt_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (beat_cnt_q == LEN_WIDTH'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      issue_cnt_q     <= issue_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (issue_cnt_q == LEN_WIDTH'(1));
    end
  end

  // Read data lands in the buffer the cycle after its address was issued,
  // tagged with whether it was the final read of the command.
  rd_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  ({inflight_last_q, bus.mem_dout}),
    .pop  (pop),
    .dout (fifo_dout),
    .occ  (occ)
  );

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = 1'b0;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = fifo_dout[DATA_WIDTH-1:0];
  assign bus.out_last  = out_valid & fifo_dout[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_stream_reader
//  Description : Self-checking bench for bram_stream_reader with a BRAM model
//                and a scoreboard of expected {last, data} beats.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_stream_reader;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_stream_reader_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) bus ();

  bram_stream_reader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM model: registered read, one cycle of latency.
  logic [DATA_WIDTH-1:0] bram [2**ADDR_WIDTH];
  always @(posedge clk) bus.mem_dout <= bram[bus.mem_addr];

  int checks   = 0;
  int failures = 0;

  logic [DATA_WIDTH:0] sb [$];

  int first_valid_cyc;
  int last_beat_cyc;
  int beats_seen;
  int done_cnt;
  int done_cyc;
  int stalls_seen;
  int start_cyc;

  logic                  prev_valid = 1'b0;
  logic                  prev_ready = 1'b0;
  logic [DATA_WIDTH-1:0] prev_data  = '0;
  logic                  prev_last  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_valid && !prev_ready) begin
        chk("stall_valid_hold", 32'(bus.out_valid), 32'd1);
        chk("stall_data_hold", {15'd0, bus.out_last, bus.out_data}, {15'd0, prev_last, prev_data});
      end
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!bus.out_ready) stalls_seen++;
        if (bus.out_ready) begin
          chk("beat_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            logic [DATA_WIDTH:0] e;
            e = sb.pop_front();
            chk("beat_data", 32'(bus.out_data), 32'(e[DATA_WIDTH-1:0]));
            chk("beat_last", 32'(bus.out_last), 32'(e[DATA_WIDTH]));
          end
          beats_seen++;
          last_beat_cyc = cyc;
        end
      end
      // The buffer must never receive a word while full and not draining.
      if (dut.u_fifo.push && !dut.u_fifo.pop) begin
        chk("fifo_no_overflow", 32'(dut.u_fifo.occ < 2'd2), 32'd1);
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic clear_stats();
    first_valid_cyc = -1;
    last_beat_cyc   = -1;
    beats_seen      = 0;
    done_cnt        = 0;
    done_cyc        = -1;
    stalls_seen     = 0;
  endtask

  // Drives a one-cycle start and pushes the expected beats; returns one
  // cycle after the start cycle.
  task automatic issue_cmd(input int addr, input int len);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = ADDR_WIDTH'(addr);
    bus.length     = LEN_WIDTH'(len);
    start_cyc      = cyc;
    for (int i = 0; i < len; i++) begin
      logic [ADDR_WIDTH-1:0] a;
      a = ADDR_WIDTH'(addr + i);
      sb.push_back({(i == len - 1), 16'h0100 + 16'(a)});
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit got;
    got = 1'b0;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < 2**ADDR_WIDTH; i++) bram[i] = 16'h0100 + 16'(i);
    clear_stats();

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_done",      32'(bus.done),      32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wen",   32'(bus.mem_wen),   32'd0);
    rst = 1'b0;

    // ---------------- basic 4-word read, ready held high ----------------
    clear_stats();
    issue_cmd(5, 4);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_done("t1_done_seen", 40);
    chk("t1_first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
    chk("t1_beats",           32'(beats_seen), 32'd4);
    chk("t1_back_to_back",    32'(last_beat_cyc - first_valid_cyc), 32'd3);
    chk("t1_done_after_last", 32'(done_cyc - last_beat_cyc), 32'd1);
    chk("t1_done_cnt",        32'(done_cnt), 32'd1);
    chk("t1_sb_empty",        32'(sb.size()), 32'd0);
    chk("t1_idle",            32'(bus.busy), 32'd0);

    // ---------------- same read, toggling ready ----------------
    clear_stats();
    issue_cmd(5, 4);
    begin
      bit got;
      logic [5:0] pat;
      got = 1'b0;
      pat = 6'b101001;   // bit i -> cycle i: 1,0,0,1,0,1
      for (int i = 0; i < 60 && !got; i++) begin
        @(posedge clk); #1;
        bus.out_ready = pat[i % 6];
        if (bus.done) got = 1'b1;
      end
      chk("t2_done_seen", 32'(got), 32'd1);
    end
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t2_beats",     32'(beats_seen), 32'd4);
    chk("t2_stalled",   32'(stalls_seen != 0), 32'd1);
    chk("t2_done_cnt",  32'(done_cnt), 32'd1);
    chk("t2_sb_empty",  32'(sb.size()), 32'd0);

    // ---------------- address wrap ----------------
    clear_stats();
    issue_cmd(254, 4);
    wait_done("t3_done_seen", 40);
    chk("t3_beats",    32'(beats_seen), 32'd4);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // ---------------- zero length ----------------
    clear_stats();
    issue_cmd(7, 0);
    chk("t4_done_pulse", 32'(bus.done), 32'd1);
    chk("t4_busy",       32'(bus.busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_beats",   32'(first_valid_cyc), 32'hFFFF_FFFF);
    chk("t4_done_cnt",   32'(done_cnt), 32'd1);

    // ---------------- start while busy is ignored ----------------
    clear_stats();
    issue_cmd(10, 3);
    @(posedge clk); #1;
    chk("t5_busy_at_restart", 32'(bus.busy), 32'd1);
    bus.start      = 1'b1;
    bus.start_addr = 8'd50;
    bus.length     = 9'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("t5_done_seen", 40);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_beats",    32'(beats_seen), 32'd3);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_idle",     32'(bus.busy), 32'd0);

    // ---------------- reset mid-command ----------------
    clear_stats();
    issue_cmd(20, 6);
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (bus.out_valid) got = 1'b1;
      end
      chk("t6_first_valid_seen", 32'(got), 32'd1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_busy",      32'(bus.busy), 32'd0);
    chk("t6_rst_done",      32'(bus.done), 32'd0);
    rst = 1'b0;
    sb.delete();
    done_cnt = 0;
    begin
      int vcnt;
      vcnt = 0;
      for (int n = 0; n < 4; n++) begin
        @(negedge clk);
        if (bus.out_valid) vcnt++;
      end
      chk("t6_no_stale_data", 32'(vcnt), 32'd0);
    end
    chk("t6_no_done", 32'(done_cnt), 32'd0);

    clear_stats();
    issue_cmd(0, 2);
    wait_done("t6_fresh_done_seen", 40);
    chk("t6_fresh_beats",    32'(beats_seen), 32'd2);
    chk("t6_fresh_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
